// File: rtl/move_entry_pkg.sv
// Shared encodings, cursor limits and FSM state type for the move-entry block.
// Also holds the cursor stepping and cell indexing helpers used by the top.
package move_entry_pkg;

  localparam logic [1:0] GS_PLAYING = 2'b00;
  localparam logic [1:0] GS_WIN_A   = 2'b01;
  localparam logic [1:0] GS_WIN_B   = 2'b10;
  localparam logic [1:0] GS_DRAW    = 2'b11;

  localparam logic [1:0] CURSOR_MIN = 2'd1;
  localparam logic [1:0] CURSOR_MAX = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

  // Opposing events in the same cycle cancel out.
  function automatic logic [1:0] cursor_step(input logic [1:0] pos, input logic dec, input logic inc);
    logic [1:0] nxt;
    nxt = pos;
    if (inc && !dec) begin
      nxt = (pos == CURSOR_MAX) ? CURSOR_MIN : pos + 2'd1;
    end else if (dec && !inc) begin
      nxt = (pos == CURSOR_MIN) ? CURSOR_MAX : pos - 2'd1;
    end else begin
      nxt = pos;
    end
    return nxt;
  endfunction

  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] r0;
    logic [3:0] c0;
    r0 = {2'b00, row} - 4'd1;
    c0 = {2'b00, col} - 4'd1;
    return (r0 * 4'd3) + c0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchronizer, saturating debouncer and
// a registered single-cycle press pulse on the accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = CNT_ZERO;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = CNT_ZERO;
        press_d = sync2_q;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/move_entry.sv
// Cursor navigation and move issue for a 3x3 board driven by five buttons.
// A move accepted together with a cursor event is issued at the old cursor;
// the cursor step is parked and applied when the move sequence finishes.
module move_entry
  import move_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic [8:0] valid,
  input  logic [1:0] game_state,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       set,
  output logic       reject
);

  logic ev_up, ev_down, ev_left, ev_right, ev_place;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(clk), .reset(reset), .btn_i(btn_up),    .press_o(ev_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk(clk), .reset(reset), .btn_i(btn_down),  .press_o(ev_down));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left  (.clk(clk), .reset(reset), .btn_i(btn_left),  .press_o(ev_left));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (.clk(clk), .reset(reset), .btn_i(btn_right), .press_o(ev_right));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_place (.clk(clk), .reset(reset), .btn_i(btn_place), .press_o(ev_place));

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic [1:0] pend_row_q, pend_row_d, pend_col_q, pend_col_d;
  logic       set_q, set_d, reject_q, reject_d;
  logic [1:0] mv_row_s, mv_col_s;
  logic       place_ok_s;

  assign mv_row_s   = cursor_step(row_q, ev_up, ev_down);
  assign mv_col_s   = cursor_step(col_q, ev_left, ev_right);
  assign place_ok_s = (game_state == GS_PLAYING) && !valid[cell_index(row_q, col_q)];

  // Only IDLE consumes events; ISSUE and HOLD freeze the cursor.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pend_row_d = pend_row_q;
    pend_col_d = pend_col_q;
    reject_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_place && place_ok_s) begin
          state_d    = ST_ISSUE;
          pend_row_d = mv_row_s;
          pend_col_d = mv_col_s;
        end else begin
          row_d    = mv_row_s;
          col_d    = mv_col_s;
          reject_d = ev_place;
        end
      end
      ST_ISSUE: state_d = ST_HOLD;
      ST_HOLD: begin
        state_d = ST_IDLE;
        row_d   = pend_row_q;
        col_d   = pend_col_q;
      end
      default: state_d = ST_IDLE;
    endcase
    set_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      row_q      <= CURSOR_MIN;
      col_q      <= CURSOR_MIN;
      pend_row_q <= CURSOR_MIN;
      pend_col_q <= CURSOR_MIN;
      set_q      <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pend_row_q <= pend_row_d;
      pend_col_q <= pend_col_d;
      set_q      <= set_d;
      reject_q   <= reject_d;
    end
  end

  assign row    = row_q;
  assign col    = col_q;
  assign set    = set_q;
  assign reject = reject_q;

endmodule

// File: tb/tb_move_entry.sv
// Randomized self-checking bench for move_entry with an event-level cursor model.
module tb_move_entry;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right, btn_place;
  logic [8:0] valid;
  logic [1:0] game_state;
  logic [1:0] row, col;
  logic       set, reject;

  move_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_place(btn_place), .valid(valid), .game_state(game_state),
    .row(row), .col(col), .set(set), .reject(reject)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_row = 1;
  int exp_col = 1;

  int cyc = 0;
  int set_cnt = 0, rej_cnt = 0, dbl_set = 0;
  int set_row = 0, set_col = 0, hold_row = 0, hold_col = 0, set_cyc = 0;
  logic set_d1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe strobes on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (set) begin
      set_cnt <= set_cnt + 1;
      set_row <= int'(row);
      set_col <= int'(col);
      if (!set_d1) set_cyc <= cyc;
      if (set_d1) dbl_set <= dbl_set + 1;
    end
    if (set_d1) begin
      hold_row <= int'(row);
      hold_col <= int'(col);
    end
    if (reject) rej_cnt <= rej_cnt + 1;
    set_d1 <= set;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_btns(input logic [4:0] m);
    btn_up    = m[0];
    btn_down  = m[1];
    btn_left  = m[2];
    btn_right = m[3];
    btn_place = m[4];
  endtask

  // m = {place, right, left, down, up}; a short hold is expected to be ignored.
  task automatic do_press(input string tag, input logic [4:0] m, input int hold, input bit effective);
    int s0, r0, t0, pr, pc, lat;
    bit ok;
    s0 = set_cnt;
    r0 = rej_cnt;
    t0 = cyc;
    pr = exp_row;
    pc = exp_col;
    ok = effective && m[4] && (game_state == 2'b00) && !valid[(pr - 1) * 3 + (pc - 1)];
    drive_btns(m);
    repeat (hold) @(negedge clk);
    drive_btns(5'b00000);
    repeat (DB + 8) @(negedge clk);
    if (effective) begin
      if (m[0] && !m[1]) exp_row = ((exp_row + 1) % 3) + 1;
      if (m[1] && !m[0]) exp_row = (exp_row % 3) + 1;
      if (m[2] && !m[3]) exp_col = ((exp_col + 1) % 3) + 1;
      if (m[3] && !m[2]) exp_col = (exp_col % 3) + 1;
    end
    check_val({tag, "_row"}, int'(row), exp_row);
    check_val({tag, "_col"}, int'(col), exp_col);
    check_val({tag, "_sets"}, set_cnt - s0, ok ? 1 : 0);
    check_val({tag, "_rejects"}, rej_cnt - r0, (effective && m[4] && !ok) ? 1 : 0);
    if (ok) begin
      check_val({tag, "_set_row"}, set_row, pr);
      check_val({tag, "_set_col"}, set_col, pc);
      check_val({tag, "_hold_row"}, hold_row, pr);
      check_val({tag, "_hold_col"}, hold_col, pc);
      lat = set_cyc - t0;
      check_val({tag, "_latency_ok"}, int'(lat >= DB + 3 && lat <= DB + 5), 1);
    end
  endtask

  initial begin
    int waited;
    logic [4:0] m;
    reset = 1'b1;
    valid = 9'd0;
    game_state = 2'b00;
    drive_btns(5'b01000);   // right already held through reset
    repeat (3) @(negedge clk);
    check_val("rst_row", int'(row), 1);
    check_val("rst_col", int'(col), 1);
    check_val("rst_set", int'(set), 0);
    check_val("rst_reject", int'(reject), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("held_early_col", int'(col), 1);
    repeat (17) @(negedge clk);
    drive_btns(5'b00000);
    repeat (DB + 8) @(negedge clk);
    exp_col = 2;
    check_val("held_col", int'(col), 2);
    check_val("held_row", int'(row), 1);

    do_press("up_wrap", 5'b00001, DB + 3, 1'b1);
    do_press("down1", 5'b00010, DB + 3, 1'b1);
    do_press("down2", 5'b00010, DB + 3, 1'b1);
    do_press("place_22", 5'b10000, DB + 3, 1'b1);

    do_press("to_r1", 5'b00001, DB + 3, 1'b1);
    do_press("to_c3", 5'b01000, DB + 3, 1'b1);
    valid = 9'b000000100;
    do_press("place_occupied", 5'b10000, DB + 3, 1'b1);
    valid = 9'd0;
    game_state = 2'b11;
    do_press("place_draw", 5'b10000, DB + 3, 1'b1);
    game_state = 2'b00;

    do_press("glitch_place", 5'b10000, DB - 1, 1'b0);
    do_press("glitch_right", 5'b01000, DB - 1, 1'b0);
    do_press("up_down", 5'b00011, DB + 3, 1'b1);
    do_press("left_right", 5'b01100, DB + 3, 1'b1);
    do_press("up_right", 5'b01001, DB + 3, 1'b1);
    do_press("place_move", 5'b11000, DB + 3, 1'b1);

    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 5))
        0: m = 5'b00001;
        1: m = 5'b00010;
        2: m = 5'b00100;
        3: m = 5'b01000;
        4: m = 5'b10000;
        default: m = 5'($urandom_range(1, 31));
      endcase
      valid = ($urandom_range(0, 1) == 0) ? 9'd0 : (9'($urandom) & 9'($urandom));
      game_state = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      do_press("rand", m, $urandom_range(DB, DB + 6), 1'b1);
    end

    // Abort a move by resetting in the ISSUE cycle.
    valid = 9'd0;
    game_state = 2'b00;
    btn_place = 1'b1;
    waited = 0;
    while (!set && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check_val("issue_seen", int'(set), 1);
    reset = 1'b1;
    btn_place = 1'b0;
    @(negedge clk);
    check_val("abort_set", int'(set), 0);
    check_val("abort_row", int'(row), 1);
    check_val("abort_col", int'(col), 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_row = 1;
    exp_col = 1;
    repeat (DB + 8) @(negedge clk);
    do_press("after_abort", 5'b10000, DB + 3, 1'b1);

    check_val("set_width", dbl_set, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required before a button level is accepted.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_up, btn_down, btn_left, btn_right, btn_place  input  1 each  raw asynchronous push-buttons, active-high.
REQ-005 valid  input  9  cell-occupied flags from the board, index = (row-1)*3 + (col-1).
REQ-006 game_state  input  2  board status: 00 playing, 01 / 10 win, 11 draw.
REQ-007 row, col  output  2 each  registered 1-based cursor position, always in 1..3.
REQ-008 set  output  1  registered one-cycle move strobe to the board.
REQ-009 reject  output  1  registered one-cycle pulse when a place request is refused.

Function
REQ-010 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples differing from the current accepted level.
REQ-011 A press event SHALL be a single-cycle pulse on the accepted-level 0->1 transition; holding a button SHALL produce no further events.
REQ-012 Up/down SHALL decrement/increment row; left/right SHALL decrement/increment col; 1 steps to 3 and 3 steps to 1 (wrap-around).
REQ-013 Simultaneous up+down events SHALL leave row unchanged; left+right likewise leave col unchanged; one vertical and one horizontal event in the same cycle SHALL both apply.
REQ-014 The FSM SHALL have states IDLE, ISSUE, HOLD; only IDLE accepts cursor and place events, and events in other states SHALL be dropped, not queued.
REQ-015 In IDLE, on a place event with game_state==00 and valid[index]==0, the next state SHALL be ISSUE; otherwise reject SHALL pulse the next cycle and the state SHALL remain IDLE.
REQ-016 A place event coinciding with a cursor event SHALL use the pre-move cursor for the check and the issued move; the cursor move SHALL still apply.
REQ-017 set SHALL be 1 exactly in ISSUE (one cycle); row and col SHALL be constant from the ISSUE cycle through the end of HOLD.
REQ-018 ISSUE SHALL go to HOLD and HOLD to IDLE unconditionally, one cycle each, so that valid settles before the next check.
REQ-019 Latency from the first stable raw sample to set SHALL be 2 + DEBOUNCE_CYCLES + 2 cycles (±1 for sampling phase).
REQ-020 Debounce counters SHALL saturate and never wrap; the counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-021 While reset is high: row=1, col=1, set=0, reject=0, FSM=IDLE, synchronizers and accepted levels 0, counters 0.
REQ-022 Reset asserted in ISSUE or HOLD SHALL abort the move; set SHALL be 0 in the cycle after reset is sampled.
REQ-023 A button already held when reset deasserts SHALL generate one press event after debounce, not earlier.

Structure
REQ-024 A shared package SHALL hold the game_state encodings (GS_PLAYING, GS_WIN_A, GS_WIN_B, GS_DRAW), CURSOR_MIN=1, CURSOR_MAX=3, and the FSM state typedef.
REQ-025 Synchronizer, debouncer and edge detector SHALL form one sub-module, btn_debounce, instantiated five times.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 btn_right held 20 cycles from reset -> exactly one col step 1->2, row stays 1.
REQ-027 btn_up pressed once from reset -> row 1->3; two btn_down presses -> row 3->1->2.
REQ-028 Cursor (2,2), valid=0, game_state=00, btn_place -> one set pulse with row=2, col=2; no reject.
REQ-029 Cursor (1,3), valid[2]=1, btn_place -> reject pulses once, set stays 0; repeated with valid=0 and game_state=11 -> reject again, set 0.
REQ-030 btn_place glitching high for 3 cycles -> no event, no set, no reject.
REQ-031 Reset asserted in the ISSUE cycle -> set 0 the next cycle; row=1, col=1, FSM=IDLE.
